// File: rtl/selector_encode_8.sv
// Sequential positional-to-binary encoder: emits the address of every set bit of a
// 256-bit vector, lowest index first, one address per valid/ready output beat.
module selector_encode_8 #(
    parameter int ADDR_W  = 8,
    parameter int GROUP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2**ADDR_W-1:0]   in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [ADDR_W-1:0]      out_seq,
    output logic                   out_last,
    output logic                   out_empty
);

    localparam int VEC_W  = 2**ADDR_W;
    localparam int NGRP   = VEC_W / GROUP_W;
    localparam int GRP_AW = $clog2(NGRP);
    localparam int BIT_AW = $clog2(GROUP_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EMIT  = 2'd1;
    localparam logic [1:0] S_EMPTY = 2'd2;

    logic [1:0]         r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [ADDR_W-1:0]  r_seq;

    logic [NGRP-1:0]    w_grp_nz;
    logic [GRP_AW-1:0]  w_grp;
    logic [GROUP_W-1:0] w_grp_bits;
    logic [BIT_AW-1:0]  w_bit;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_single;
    logic [VEC_W-1:0]   w_clr_mask;
    logic               w_emit;
    logic               w_empty;

    // First level: which 16-bit groups hold any remaining bit.
    for (genvar g = 0; g < NGRP; g++) begin : g_grp_nz
        assign w_grp_nz[g] = |r_vec[g*GROUP_W +: GROUP_W];
    end

    always_comb begin
        w_grp = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (w_grp_nz[g]) begin
                w_grp = GRP_AW'(g);
            end
        end
    end

    assign w_grp_bits = r_vec[{w_grp, {BIT_AW{1'b0}}} +: GROUP_W];

    always_comb begin
        w_bit = '0;
        for (int b = GROUP_W - 1; b >= 0; b--) begin
            if (w_grp_bits[b]) begin
                w_bit = BIT_AW'(b);
            end
        end
    end

    assign w_addr     = {w_grp, w_bit};
    // Exactly one bit left (r_vec is never zero while emitting).
    assign w_single   = ((r_vec & (r_vec - VEC_W'(1))) == '0);
    assign w_clr_mask = ~(VEC_W'(1) << w_addr);

    assign w_emit  = (r_state == S_EMIT);
    assign w_empty = (r_state == S_EMPTY);

    assign in_ready  = !(w_emit || w_empty);
    assign out_valid = w_emit || w_empty;
    assign out_addr  = w_emit ? w_addr : '0;
    assign out_seq   = w_emit ? r_seq  : '0;
    assign out_last  = w_emit ? w_single : w_empty;
    assign out_empty = w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_seq   <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_seq   <= '0;
        end else begin
            case (r_state)
                S_EMIT: begin
                    if (out_ready) begin
                        r_vec <= r_vec & w_clr_mask;
                        r_seq <= r_seq + 1'b1;
                        if (w_single) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_EMPTY: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    // Unused encodings behave as IDLE.
                    r_state <= S_IDLE;
                    if (in_valid) begin
                        r_vec   <= in_vec;
                        r_seq   <= '0;
                        r_state <= (|in_vec) ? S_EMIT : S_EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_selector_encode_8.sv
// Self-checking bench for selector_encode_8: scoreboard of expected beats per vector.
module tb_selector_encode_8;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_addr;
    logic [7:0]   out_seq;
    logic         out_last;
    logic         out_empty;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] seq;
        logic       last;
        logic       empty;
    } beat_t;

    beat_t exp_q[$];
    int    checks;
    int    errors;

    selector_encode_8 #(.ADDR_W(8), .GROUP_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_seq   (out_seq),
        .out_last  (out_last),
        .out_empty (out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build the expected beat list for a vector and hand it to the DUT.
    task automatic send_vec(input logic [255:0] v);
        int cnt;
        int k;
        beat_t b;
        cnt = 0;
        for (int i = 0; i < 256; i++) cnt += int'(v[i]);
        if (cnt == 0) begin
            b.addr = 8'd0; b.seq = 8'd0; b.last = 1'b1; b.empty = 1'b1;
            exp_q.push_back(b);
        end else begin
            k = 0;
            for (int i = 0; i < 256; i++) begin
                if (v[i]) begin
                    b.addr = 8'(i); b.seq = 8'(k); b.last = (k == cnt - 1); b.empty = 1'b0;
                    exp_q.push_back(b);
                    k++;
                end
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = 'x;
    endtask

    // Consume beats with optional random stalls, checking each against the scoreboard.
    task automatic drain(input int stall_pct, input int budget);
        int    cyc;
        int    stall;
        logic  hold;
        beat_t prev;
        beat_t got;
        beat_t exp;
        cyc = 0; stall = 0; hold = 1'b0; prev = '0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            got = {out_addr, out_seq, out_last, out_empty};
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL beat_valid: out_valid=%b required 1 (pending %0d)", out_valid, exp_q.size());
            end
            if (hold) begin
                checks++;
                if (got !== prev) begin
                    errors++;
                    $display("FAIL stall_stable: outputs %h required %h", got, prev);
                end
            end
            if (stall > 0) begin
                stall--;
                out_ready = 1'b0;
            end else if ($urandom_range(0, 99) < stall_pct) begin
                stall = 4;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL beat: addr=%h seq=%0d last=%b empty=%b required addr=%h seq=%0d last=%b empty=%b",
                             got.addr, got.seq, got.last, got.empty, exp.addr, exp.seq, exp.last, exp.empty);
                end
                hold = 1'b0;
            end else begin
                hold = out_valid;
                prev = got;
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_idle: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_vec = 'x; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_addr, out_seq, out_last, out_empty} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b addr=%h seq=%h last=%b empty=%b required 1 0 00 00 0 0",
                     in_ready, out_valid, out_addr, out_seq, out_last, out_empty);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_x_vec: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single_bit;
        logic [255:0] v;
        v = '0; v[8'hA5] = 1'b1;
        send_vec(v);
        drain(0, 20);
    endtask

    task automatic test_sparse;
        logic [255:0] v;
        v = '0; v[0] = 1'b1; v[17] = 1'b1; v[255] = 1'b1;
        send_vec(v);
        drain(0, 20);
    endtask

    task automatic test_empty;
        send_vec('0);
        drain(0, 20);
    endtask

    task automatic test_full_backpressure;
        send_vec('1);
        drain(30, 5000);
    endtask

    task automatic test_round_trip;
        logic [255:0] onehot;
        for (int a = 0; a < 256; a++) begin
            onehot = '0;
            onehot[a] = 1'b1;
            send_vec(onehot);
            drain(0, 10);
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] v;
        for (int n = 0; n < 6; n++) begin
            v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            v = v & {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            v = v & {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_vec(v);
            drain(20, 2000);
        end
    endtask

    // Present beats 3 and 4, then abort on beat 4 via flush or rst.
    task automatic test_abort(input logic use_rst);
        logic [255:0] v;
        logic [255:0] nxt;
        v = '0; v[3] = 1'b1; v[4] = 1'b1; v[5] = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_vec = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_vec = 'x;
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if ({out_valid, out_addr, out_seq, out_last} !== {1'b1, 8'd3, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_beat0: vld=%b addr=%h seq=%0d last=%b required 1 03 0 0",
                     out_valid, out_addr, out_seq, out_last);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_addr, out_seq, out_last} !== {1'b1, 8'd4, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL abort_beat1: vld=%b addr=%h seq=%0d last=%b required 1 04 1 0",
                     out_valid, out_addr, out_seq, out_last);
        end
        if (use_rst) begin
            rst = 1'b1;
            #1;
            checks++;
            if ({out_valid, in_ready, out_seq} !== {1'b0, 1'b1, 8'd0}) begin
                errors++;
                $display("FAIL rst_abort: vld=%b rdy=%b seq=%0d required 0 1 0", out_valid, in_ready, out_seq);
            end
            @(negedge clk);
            rst = 1'b0;
        end else begin
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
                errors++;
                $display("FAIL flush_abort: vld=%b rdy=%b required 0 1", out_valid, in_ready);
            end
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_beat: out_valid=%b required 0", out_valid);
            end
        end
        out_ready = 1'b0;
        nxt = '0; nxt[200] = 1'b1; nxt[201] = 1'b1;
        send_vec(nxt);
        drain(0, 20);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_bit();
        test_sparse();
        test_empty();
        test_full_backpressure();
        test_round_trip();
        test_back_to_back();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
